sb_ctrl: RTL and testbench

// - Controller for the circular store buffer: allocates entries at dispatch and captures store addr/data.
// - Marks entries committed in ROB order, rolls back uncommitted entries on flush.
// - Drains committed stores in order to memory through a valid/ready + done handshake.
// - Drives sb_wb_vector_o / sb_commit_pt_o, which feed prev_st_check in the issue stage.

---
 rtl/sb_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_sb_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_ctrl.sv
// sb_ctrl -- circular store buffer controller.
//
// Allocates entries at dispatch, captures store addr/data from execute, marks
// entries committed in ROB order, squashes uncommitted entries on flush, and
// drains committed entries in order to memory with a valid/ready + done
// handshake.
//
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   alloc_v_i / alloc_ready_o       allocation request / buffer not full
//   alloc_sb_num_o                  entry granted to an accepted allocation
//   fill_v_i, fill_sb_num_i,
//   fill_addr_i, fill_data_i        execute-stage write of one entry
//   commit_v_i                      retire the oldest uncommitted store
//   flush_i                         squash every uncommitted entry
//   mem_v_o, mem_addr_o, mem_data_o drain request toward memory
//   mem_ready_i, mem_done_i         memory accept / memory write complete
//   sb_wb_vector_o                  bit k set when entry k is not live
//   sb_commit_pt_o                  head pointer (oldest live entry)
//   empty_o                         no live entries
//   perf_full_cycles_o,
//   perf_drained_o                  saturating perf counters (SB_PERF_EN only)
//
// Build option: define SB_PERF_EN to add the two perf counter outputs.
module sb_ctrl #(
  parameter int SB_ENTRY   = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        alloc_v_i,
  output logic                        alloc_ready_o,
  output logic [$clog2(SB_ENTRY)-1:0] alloc_sb_num_o,
  input  logic                        fill_v_i,
  input  logic [$clog2(SB_ENTRY)-1:0] fill_sb_num_i,
  input  logic [ADDR_WIDTH-1:0]       fill_addr_i,
  input  logic [DATA_WIDTH-1:0]       fill_data_i,
  input  logic                        commit_v_i,
  input  logic                        flush_i,
  output logic                        mem_v_o,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0]       mem_data_o,
  input  logic                        mem_ready_i,
  input  logic                        mem_done_i,
  output logic [SB_ENTRY-1:0]         sb_wb_vector_o,
  output logic [$clog2(SB_ENTRY)-1:0] sb_commit_pt_o,
`ifdef SB_PERF_EN
  output logic [31:0]                 perf_full_cycles_o,
  output logic [31:0]                 perf_drained_o,
`endif
  output logic                        empty_o
);

  localparam int PW = $clog2(SB_ENTRY);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} st_e;

  st_e st_q, st_d;

  logic [SB_ENTRY-1:0] valid_q, valid_d;
  logic [SB_ENTRY-1:0] filled_q, filled_d;
  logic [SB_ENTRY-1:0] cmtd_q, cmtd_d;
  logic [ADDR_WIDTH-1:0] addr_q [SB_ENTRY];
  logic [DATA_WIDTH-1:0] data_q [SB_ENTRY];

  logic [PW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, sq_cnt;

  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [DATA_WIDTH-1:0] mdata_q;

  logic full, alloc_go, commit_go, fill_go, free_go, ld_mem;

  assign full     = (count_q == CW'(SB_ENTRY));
  assign alloc_go = alloc_v_i & ~full & ~flush_i;
  assign fill_go  = fill_v_i & valid_q[fill_sb_num_i];
  // Entry at cmt is valid & uncommitted exactly when something is left to
  // commit; this also resolves the full case where cmt == tail.
  assign commit_go = commit_v_i & valid_q[cmt_q] & ~cmtd_q[cmt_q];
  assign free_go   = (st_q == S_WAIT) & mem_done_i;

  // Per-entry state and pointers.
  always_comb begin
    valid_d  = valid_q;
    filled_d = filled_q;
    cmtd_d   = cmtd_q;
    head_d   = head_q;
    cmt_d    = cmt_q;
    tail_d   = tail_q;
    if (fill_go) filled_d[fill_sb_num_i] = 1'b1;
    if (alloc_go) begin
      valid_d[tail_q]  = 1'b1;
      filled_d[tail_q] = 1'b0;
      cmtd_d[tail_q]   = 1'b0;
      tail_d           = tail_q + PW'(1);
    end
    // Commit lands before flush so a same-cycle commit survives the squash.
    if (commit_go) begin
      cmtd_d[cmt_q] = 1'b1;
      cmt_d         = cmt_q + PW'(1);
    end
    if (free_go) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (flush_i) begin
      // Live-uncommitted entries are exactly [cmt, tail).
      valid_d = valid_d & cmtd_d;
      tail_d  = cmt_d;
    end
  end

  // Number of entries squashed by a flush this cycle (alloc is blocked on
  // flush, and the freed head is always committed, so valid_q is enough).
  always_comb begin
    sq_cnt = '0;
    for (int k = 0; k < SB_ENTRY; k++)
      sq_cnt = sq_cnt + CW'(valid_q[k] & ~cmtd_d[k]);
  end

  always_comb begin
    count_d = count_q + CW'(alloc_go) - CW'(free_go);
    if (flush_i) count_d = count_d - sq_cnt;
  end

  // Drain FSM.
  always_comb begin
    st_d   = st_q;
    ld_mem = 1'b0;
    case (st_q)
      S_IDLE:
        if (valid_q[head_q] & filled_q[head_q] & cmtd_q[head_q]) begin
          st_d   = S_REQ;
          ld_mem = 1'b1;
        end
      S_REQ:  if (mem_ready_i) st_d = S_WAIT;
      S_WAIT: if (mem_done_i)  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q     <= S_IDLE;
      valid_q  <= '0;
      filled_q <= '0;
      cmtd_q   <= '0;
      head_q   <= '0;
      cmt_q    <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      maddr_q  <= '0;
      mdata_q  <= '0;
      for (int k = 0; k < SB_ENTRY; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      st_q     <= st_d;
      valid_q  <= valid_d;
      filled_q <= filled_d;
      cmtd_q   <= cmtd_d;
      head_q   <= head_d;
      cmt_q    <= cmt_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      if (fill_go) begin
        addr_q[fill_sb_num_i] <= fill_addr_i;
        data_q[fill_sb_num_i] <= fill_data_i;
      end
      // Snapshot the head entry so the request stays stable while in REQ.
      if (ld_mem) begin
        maddr_q <= addr_q[head_q];
        mdata_q <= data_q[head_q];
      end
    end
  end

  assign alloc_ready_o  = ~full;
  assign alloc_sb_num_o = tail_q;
  assign mem_v_o        = (st_q == S_REQ);
  assign mem_addr_o     = maddr_q;
  assign mem_data_o     = mdata_q;
  // A freed entry drops valid, so "not valid" also covers written-back.
  assign sb_wb_vector_o = ~valid_q;
  assign sb_commit_pt_o = head_q;
  assign empty_o        = (count_q == '0);

`ifdef SB_PERF_EN
  logic [31:0] pfull_q, pdrn_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pfull_q <= '0;
      pdrn_q  <= '0;
    end else begin
      if (alloc_v_i && full && (pfull_q != '1)) pfull_q <= pfull_q + 32'd1;
      if (free_go && (pdrn_q != '1))            pdrn_q  <= pdrn_q + 32'd1;
    end
  end

  assign perf_full_cycles_o = pfull_q;
  assign perf_drained_o     = pdrn_q;
`endif

endmodule

// File: tb/tb_sb_ctrl.sv
module tb_sb_ctrl;
  localparam int SB_ENTRY = 8;
  localparam int PW = 3;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          alloc_v_i = 1'b0;
  logic          alloc_ready_o;
  logic [PW-1:0] alloc_sb_num_o;
  logic          fill_v_i = 1'b0;
  logic [PW-1:0] fill_sb_num_i = '0;
  logic [AW-1:0] fill_addr_i = '0;
  logic [DW-1:0] fill_data_i = '0;
  logic          commit_v_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          mem_v_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_ready_i = 1'b0;
  logic          mem_done_i = 1'b0;
  logic [SB_ENTRY-1:0] sb_wb_vector_o;
  logic [PW-1:0] sb_commit_pt_o;
  logic          empty_o;
`ifdef SB_PERF_EN
  logic [31:0]   perf_full_cycles_o, perf_drained_o;
`endif

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] data_log[$];
  int            cpt_log[$];

  sb_ctrl #(.SB_ENTRY(SB_ENTRY), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o), .alloc_sb_num_o(alloc_sb_num_o),
    .fill_v_i(fill_v_i), .fill_sb_num_i(fill_sb_num_i),
    .fill_addr_i(fill_addr_i), .fill_data_i(fill_data_i),
    .commit_v_i(commit_v_i), .flush_i(flush_i),
    .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ready_i(mem_ready_i), .mem_done_i(mem_done_i),
    .sb_wb_vector_o(sb_wb_vector_o), .sb_commit_pt_o(sb_commit_pt_o),
`ifdef SB_PERF_EN
    .perf_full_cycles_o(perf_full_cycles_o), .perf_drained_o(perf_drained_o),
`endif
    .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_v_i = 0; fill_v_i = 0; commit_v_i = 0; flush_i = 0;
    mem_ready_i = 0; mem_done_i = 0;
    reset_i = 1;
    tick();
    reset_i = 0;
  endtask

  task automatic alloc_n(input int n);
    alloc_v_i = 1;
    for (int i = 0; i < n; i++) tick();
    alloc_v_i = 0;
  endtask

  task automatic fill(input logic [PW-1:0] idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    fill_v_i = 1; fill_sb_num_i = idx; fill_addr_i = a; fill_data_i = d;
    tick();
    fill_v_i = 0;
  endtask

  task automatic commit_n(input int n);
    commit_v_i = 1;
    for (int i = 0; i < n; i++) tick();
    commit_v_i = 0;
  endtask

  // Memory model: accept immediately, signal done two cycles after acceptance.
  // Logs each request and the commit pointer after each completion.
  task automatic mem_serve(input int n);
    int pend, dly, nd;
    pend = 0; dly = 0; nd = 0;
    mem_ready_i = 1;
    for (int c = 0; c < 40 * n && nd < n; c++) begin
      mem_done_i = 0;
      if (pend != 0) begin
        if (dly == 0) begin mem_done_i = 1; pend = 0; nd++; end
        else dly--;
      end
      if (mem_v_o) begin
        addr_log.push_back(mem_addr_o);
        data_log.push_back(mem_data_o);
        pend = 1; dly = 1;
      end
      tick();
      if (mem_done_i) cpt_log.push_back(int'(sb_commit_pt_o));
    end
    mem_done_i = 0;
    mem_ready_i = 0;
  endtask

  task automatic clear_logs();
    addr_log.delete(); data_log.delete(); cpt_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (alloc_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", alloc_ready_o); end
    tests++; if (alloc_sb_num_o !== 3'd0) begin fails++; $display("FAIL reset_sbnum: got %0d exp 0", alloc_sb_num_o); end
    tests++; if (mem_v_o !== 1'b0) begin fails++; $display("FAIL reset_memv: got %b exp 0", mem_v_o); end
    tests++; if (sb_wb_vector_o !== 8'hFF) begin fails++; $display("FAIL reset_wb: got %h exp ff", sb_wb_vector_o); end
    tests++; if (sb_commit_pt_o !== 3'd0) begin fails++; $display("FAIL reset_cpt: got %0d exp 0", sb_commit_pt_o); end
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b exp 1", empty_o); end
  endtask

  task automatic test_fill_to_full();
    logic [PW-1:0] exp_n;
    do_reset();
    alloc_v_i = 1;
    for (int i = 0; i < 8; i++) begin
      exp_n = PW'(i);
      tests++; if (alloc_sb_num_o !== exp_n) begin fails++; $display("FAIL full_sbnum%0d: got %0d exp %0d", i, alloc_sb_num_o, exp_n); end
      tests++; if (alloc_ready_o !== 1'b1) begin fails++; $display("FAIL full_ready%0d: got %b exp 1", i, alloc_ready_o); end
      tick();
    end
    tests++; if (alloc_ready_o !== 1'b0) begin fails++; $display("FAIL full_notready: got %b exp 0", alloc_ready_o); end
    tests++; if (sb_wb_vector_o !== 8'h00) begin fails++; $display("FAIL full_wb: got %h exp 00", sb_wb_vector_o); end
    tests++; if (empty_o !== 1'b0) begin fails++; $display("FAIL full_empty: got %b exp 0", empty_o); end
    tick(); // 9th request while full: ignored
    alloc_v_i = 0;
    tests++; if (alloc_sb_num_o !== 3'd0) begin fails++; $display("FAIL full_ignored_sbnum: got %0d exp 0", alloc_sb_num_o); end
    tests++; if (alloc_ready_o !== 1'b0) begin fails++; $display("FAIL full_ignored_ready: got %b exp 0", alloc_ready_o); end
  endtask

  task automatic test_drain();
    do_reset();
    clear_logs();
    alloc_n(2);
    fill(3'd0, 16'h0010, 16'h00AB);
    fill(3'd1, 16'h0012, 16'h00CD);
    commit_n(2);
    tests++; if (sb_commit_pt_o !== 3'd0) begin fails++; $display("FAIL drain_cpt0: got %0d exp 0", sb_commit_pt_o); end
    mem_serve(2);
    tests++; if (cpt_log.size() != 2 || addr_log.size() != 2) begin
      fails++; $display("FAIL drain_count: got %0d done exp 2", cpt_log.size());
    end else begin
      tests++; if (addr_log[0] !== 16'h0010) begin fails++; $display("FAIL drain_addr0: got %h exp 0010", addr_log[0]); end
      tests++; if (data_log[0] !== 16'h00AB) begin fails++; $display("FAIL drain_data0: got %h exp 00ab", data_log[0]); end
      tests++; if (addr_log[1] !== 16'h0012) begin fails++; $display("FAIL drain_addr1: got %h exp 0012", addr_log[1]); end
      tests++; if (data_log[1] !== 16'h00CD) begin fails++; $display("FAIL drain_data1: got %h exp 00cd", data_log[1]); end
      tests++; if (cpt_log[0] != 1) begin fails++; $display("FAIL drain_cpt1: got %0d exp 1", cpt_log[0]); end
      tests++; if (cpt_log[1] != 2) begin fails++; $display("FAIL drain_cpt2: got %0d exp 2", cpt_log[1]); end
    end
    tests++; if (sb_wb_vector_o !== 8'hFF) begin fails++; $display("FAIL drain_wb: got %h exp ff", sb_wb_vector_o); end
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL drain_empty: got %b exp 1", empty_o); end
  endtask

  task automatic test_flush_commit();
    do_reset();
    alloc_n(4);
    commit_n(1);
    commit_v_i = 1; flush_i = 1;
    tick();
    commit_v_i = 0; flush_i = 0;
    tests++; if (alloc_sb_num_o !== 3'd2) begin fails++; $display("FAIL flush_tail: got %0d exp 2", alloc_sb_num_o); end
    tests++; if (sb_wb_vector_o !== 8'hFC) begin fails++; $display("FAIL flush_wb: got %h exp fc", sb_wb_vector_o); end
    tests++; if (empty_o !== 1'b0) begin fails++; $display("FAIL flush_empty: got %b exp 0", empty_o); end
    // Alloc during flush is dropped.
    alloc_v_i = 1; flush_i = 1;
    tick();
    flush_i = 0;
    tests++; if (alloc_sb_num_o !== 3'd2) begin fails++; $display("FAIL flush_alloc_drop: got %0d exp 2", alloc_sb_num_o); end
    tick();
    alloc_v_i = 0;
    tests++; if (alloc_sb_num_o !== 3'd3) begin fails++; $display("FAIL flush_realloc: got %0d exp 3", alloc_sb_num_o); end
    tests++; if (sb_wb_vector_o !== 8'hF8) begin fails++; $display("FAIL flush_realloc_wb: got %h exp f8", sb_wb_vector_o); end
  endtask

  task automatic test_stall();
    int seen;
    do_reset();
    alloc_n(1);
    fill(3'd0, 16'h1234, 16'h5678);
    commit_n(1);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (mem_v_o) seen = 1; else tick();
    end
    tests++; if (seen != 1) begin fails++; $display("FAIL stall_req_timeout: got no request exp mem_v_o=1"); end
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if (mem_v_o !== 1'b1 || mem_addr_o !== 16'h1234 || mem_data_o !== 16'h5678 ||
          sb_commit_pt_o !== 3'd0 || alloc_sb_num_o !== 3'd1) begin
        fails++;
        $display("FAIL stall_hold%0d: got v=%b a=%h d=%h cpt=%0d tail=%0d exp v=1 a=1234 d=5678 cpt=0 tail=1",
                 c, mem_v_o, mem_addr_o, mem_data_o, sb_commit_pt_o, alloc_sb_num_o);
      end
    end
    mem_ready_i = 1;
    tick();
    mem_ready_i = 0;
    tests++; if (mem_v_o !== 1'b0) begin fails++; $display("FAIL stall_wait_v: got %b exp 0", mem_v_o); end
    tests++; if (sb_commit_pt_o !== 3'd0) begin fails++; $display("FAIL stall_wait_cpt: got %0d exp 0", sb_commit_pt_o); end
    mem_done_i = 1;
    tick();
    mem_done_i = 0;
    tests++; if (sb_commit_pt_o !== 3'd1) begin fails++; $display("FAIL stall_done_cpt: got %0d exp 1", sb_commit_pt_o); end
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL stall_done_empty: got %b exp 1", empty_o); end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] exp_n;
    do_reset();
    clear_logs();
    alloc_n(6);
    for (int i = 0; i < 6; i++) fill(PW'(i), AW'(16'h0100 + i), DW'(16'h0200 + i));
    commit_n(6);
    mem_serve(6);
    tests++; if (sb_commit_pt_o !== 3'd6) begin fails++; $display("FAIL wrap_head6: got %0d exp 6", sb_commit_pt_o); end
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL wrap_empty6: got %b exp 1", empty_o); end
    clear_logs();
    alloc_v_i = 1;
    for (int i = 0; i < 3; i++) begin
      exp_n = PW'(6 + i);
      tests++; if (alloc_sb_num_o !== exp_n) begin fails++; $display("FAIL wrap_sbnum%0d: got %0d exp %0d", i, alloc_sb_num_o, exp_n); end
      tick();
    end
    alloc_v_i = 0;
    fill(3'd6, 16'h0306, 16'h0406);
    fill(3'd7, 16'h0307, 16'h0407);
    fill(3'd0, 16'h0300, 16'h0400);
    commit_n(3);
    mem_serve(3);
    tests++; if (cpt_log.size() != 3) begin
      fails++; $display("FAIL wrap_count: got %0d done exp 3", cpt_log.size());
    end else begin
      tests++; if (cpt_log[0] != 7) begin fails++; $display("FAIL wrap_cpt7: got %0d exp 7", cpt_log[0]); end
      tests++; if (cpt_log[1] != 0) begin fails++; $display("FAIL wrap_cpt0: got %0d exp 0", cpt_log[1]); end
      tests++; if (cpt_log[2] != 1) begin fails++; $display("FAIL wrap_cpt1: got %0d exp 1", cpt_log[2]); end
      tests++; if (addr_log[1] !== 16'h0307) begin fails++; $display("FAIL wrap_addr7: got %h exp 0307", addr_log[1]); end
      tests++; if (data_log[2] !== 16'h0400) begin fails++; $display("FAIL wrap_data0: got %h exp 0400", data_log[2]); end
    end
  endtask

  task automatic test_reset_in_wait();
    int seen;
    do_reset();
    alloc_n(3);
    fill(3'd0, 16'hAAA0, 16'hBBB0);
    fill(3'd1, 16'hAAA1, 16'hBBB1);
    fill(3'd2, 16'hAAA2, 16'hBBB2);
    commit_n(3);
    mem_ready_i = 1;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (mem_v_o) seen = 1; else tick();
    end
    tests++; if (seen != 1) begin fails++; $display("FAIL rstw_req_timeout: got no request exp mem_v_o=1"); end
    tick(); // accepted, now waiting for done
    mem_ready_i = 0;
    tests++; if (mem_v_o !== 1'b0) begin fails++; $display("FAIL rstw_inwait_v: got %b exp 0", mem_v_o); end
    reset_i = 1;
    tick();
    reset_i = 0;
    tests++;
    if (alloc_ready_o !== 1'b1 || alloc_sb_num_o !== 3'd0 || mem_v_o !== 1'b0 ||
        sb_wb_vector_o !== 8'hFF || sb_commit_pt_o !== 3'd0 || empty_o !== 1'b1) begin
      fails++;
      $display("FAIL rstw_outputs: got rdy=%b n=%0d v=%b wb=%h cpt=%0d e=%b exp 1 0 0 ff 0 1",
               alloc_ready_o, alloc_sb_num_o, mem_v_o, sb_wb_vector_o, sb_commit_pt_o, empty_o);
    end
    mem_done_i = 1; // late completion of the aborted drain
    tick();
    mem_done_i = 0;
    tick(); tick();
    tests++; if (sb_commit_pt_o !== 3'd0) begin fails++; $display("FAIL rstw_late_cpt: got %0d exp 0", sb_commit_pt_o); end
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL rstw_late_empty: got %b exp 1", empty_o); end
    tests++; if (sb_wb_vector_o !== 8'hFF) begin fails++; $display("FAIL rstw_late_wb: got %h exp ff", sb_wb_vector_o); end
    tests++; if (mem_v_o !== 1'b0) begin fails++; $display("FAIL rstw_late_v: got %b exp 0", mem_v_o); end
  endtask

  initial begin
    test_reset();
    test_fill_to_full();
    test_drain();
    test_flush_commit();
    test_stall();
    test_wrap();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
